// File: rtl/xor_frame_acc.sv
// xor_frame_acc
// Streaming XOR accumulator. It folds a frame of up to FRAME_LEN words of
// WIDTH bits into one XOR word, one parity bit, a word count and a
// short-frame flag. Input and output both use valid/ready handshakes.
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous reset, active low
//   in_valid    input word present
//   in_ready    block accepts an input word this cycle
//   in_data     input word [WIDTH-1:0]
//   in_last     closes the frame early (sampled only on accept)
//   out_valid   result present
//   out_ready   consumer takes the result
//   out_xor     XOR of all words in the frame [WIDTH-1:0]
//   out_parity  XOR-reduce of out_xor
//   out_count   number of words in the frame [CW-1:0]
//   out_short   frame closed by in_last before FRAME_LEN words
//
// Build option
//   XOR_FRAME_ACC_OVERLAP_EN: when defined, a word can be accepted in the
//   same cycle as the result handshake, so frames run back to back with no
//   bubble. When undefined, there is one idle cycle per frame.
//
// State  | meaning
// -------+-----------------------------------------------------------
// ACCUM  | collecting words, in_ready=1, out_valid=0
// HOLD   | result registered and presented, waiting for out_ready

module xor_frame_acc #(
   parameter int WIDTH     = 8,
   parameter int FRAME_LEN = 4,
   parameter int CW        = $clog2(FRAME_LEN + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_xor,
   output logic             out_parity,
   output logic [CW-1:0]    out_count,
   output logic             out_short
);

   typedef enum logic {
      ST_ACCUM = 1'b0,
      ST_HOLD  = 1'b1
   } state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_acc;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_out_xor;
   logic             r_out_parity;
   logic [CW-1:0]    r_out_count;
   logic             r_out_short;

   logic             w_accept;
   logic [WIDTH-1:0] w_acc_base;
   logic [WIDTH-1:0] w_acc_next;
   logic [CW-1:0]    w_cnt_base;
   logic [CW-1:0]    w_cnt_next;
   logic             w_close;
   logic             w_short;

`ifdef XOR_FRAME_ACC_OVERLAP_EN
   assign in_ready = (r_state == ST_ACCUM) || out_ready;
`else
   assign in_ready = (r_state == ST_ACCUM);
`endif

   assign out_valid  = (r_state == ST_HOLD);
   assign out_xor    = r_out_xor;
   assign out_parity = r_out_parity;
   assign out_count  = r_out_count;
   assign out_short  = r_out_short;

   assign w_accept = in_valid && in_ready;

   // A word accepted in HOLD (overlap only) begins a fresh frame, so it
   // folds into zero rather than into the held accumulator.
   assign w_acc_base = (r_state == ST_HOLD) ? '0 : r_acc;
   assign w_cnt_base = (r_state == ST_HOLD) ? '0 : r_cnt;
   assign w_acc_next = w_acc_base ^ in_data;
   assign w_cnt_next = w_cnt_base + CW'(1);
   assign w_close    = (w_cnt_next == CW'(FRAME_LEN)) || in_last;
   assign w_short    = in_last && (w_cnt_next < CW'(FRAME_LEN));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= ST_ACCUM;
         r_acc        <= '0;
         r_cnt        <= '0;
         r_out_xor    <= '0;
         r_out_parity <= 1'b0;
         r_out_count  <= '0;
         r_out_short  <= 1'b0;
      end else if (w_accept) begin
         r_acc <= w_acc_next;
         r_cnt <= w_cnt_next;
         if (w_close) begin
            r_out_xor    <= w_acc_next;
            r_out_parity <= ^w_acc_next;
            r_out_count  <= w_cnt_next;
            r_out_short  <= w_short;
            r_state      <= ST_HOLD;
         end else begin
            r_state <= ST_ACCUM;
         end
      end else if ((r_state == ST_HOLD) && out_ready) begin
         r_acc   <= '0;
         r_cnt   <= '0;
         r_state <= ST_ACCUM;
      end
   end

endmodule

// File: tb/tb_xor_frame_acc.sv
module tb_xor_frame_acc;

   localparam int WIDTH     = 8;
   localparam int FRAME_LEN = 4;
   localparam int CW        = $clog2(FRAME_LEN + 1);

   logic             clk;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             in_last;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_xor;
   logic             out_parity;
   logic [CW-1:0]    out_count;
   logic             out_short;

   int n_cmp = 0;
   int n_err = 0;

   xor_frame_acc #(.WIDTH(WIDTH), .FRAME_LEN(FRAME_LEN)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .in_last    (in_last),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_xor    (out_xor),
      .out_parity (out_parity),
      .out_count  (out_count),
      .out_short  (out_short)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct packed {
      logic [31:0] words;   // word i in bits [8*i +: 8]
      logic [3:0]  lasts;   // bit i = in_last on word i
      logic [2:0]  n;
      logic [7:0]  x;
      logic        p;
      logic [2:0]  c;
      logic        s;
   } vec_t;

   vec_t vecs[7];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Called mid-cycle; returns 1 time unit after the accepting edge.
   task automatic send_word(input logic [7:0] d, input logic l);
      int n;
      n = 0;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = l;
      while (!in_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (n >= 20) begin
         n_cmp++;
         n_err++;
         $display("FAIL accept_timeout: got in_ready=0 expected in_ready=1 within 20 cycles");
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic check_result(input string tag, input logic [7:0] x, input logic p,
                               input logic [2:0] c, input logic s);
      check({tag, "_valid"},  32'(out_valid),  32'd1);
      check({tag, "_xor"},    32'(out_xor),    32'(x));
      check({tag, "_parity"}, 32'(out_parity), 32'(p));
      check({tag, "_count"},  32'(out_count),  32'(c));
      check({tag, "_short"},  32'(out_short),  32'(s));
   endtask

   task automatic handshake(input string tag);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
   endtask

   function automatic vec_t mk(logic [31:0] w, logic [3:0] l, logic [2:0] n,
                               logic [7:0] x, logic p, logic [2:0] c, logic s);
      vec_t v;
      v.words = w; v.lasts = l; v.n = n; v.x = x; v.p = p; v.c = c; v.s = s;
      return v;
   endfunction

   initial begin
      vecs[0] = mk(32'h08040201, 4'b0000, 3'd4, 8'h0F, 1'b0, 3'd4, 1'b0);
      vecs[1] = mk(32'h000001FF, 4'b0010, 3'd2, 8'hFE, 1'b1, 3'd2, 1'b1);
      vecs[2] = mk(32'h80402010, 4'b1000, 3'd4, 8'hF0, 1'b0, 3'd4, 1'b0);
      vecs[3] = mk(32'h0000005A, 4'b0001, 3'd1, 8'h5A, 1'b0, 3'd1, 1'b1);
      vecs[4] = mk(32'h00060503, 4'b0100, 3'd3, 8'h00, 1'b0, 3'd3, 1'b1);
      vecs[5] = mk(32'h01000080, 4'b0000, 3'd4, 8'h81, 1'b0, 3'd4, 1'b0);
      vecs[6] = mk(32'h0002017F, 4'b0100, 3'd3, 8'h7C, 1'b1, 3'd3, 1'b1);

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      in_last   = 1'b0;
      out_ready = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_valid",  32'(out_valid),  32'd0);
      check("rst_xor",    32'(out_xor),    32'd0);
      check("rst_parity", 32'(out_parity), 32'd0);
      check("rst_count",  32'(out_count),  32'd0);
      check("rst_short",  32'(out_short),  32'd0);
      rst_n = 1'b1;
      #1;
      check("rst_ready", 32'(in_ready), 32'd1);

      // Table-driven frames
      for (int v = 0; v < 7; v++) begin
         for (int i = 0; i < int'(vecs[v].n); i++) begin
            send_word(vecs[v].words[8*i +: 8], vecs[v].lasts[i]);
            if (i < int'(vecs[v].n) - 1)
               check($sformatf("v%0d_w%0d_no_valid", v, i), 32'(out_valid), 32'd0);
         end
         check_result($sformatf("v%0d", v), vecs[v].x, vecs[v].p, vecs[v].c, vecs[v].s);
         check($sformatf("v%0d_hold_ready", v), 32'(in_ready), 32'd0);
         handshake($sformatf("v%0d", v));
      end

      // Stall in HOLD for 5 cycles with a word waiting: nothing absorbed
      send_word(8'h11, 1'b0);
      send_word(8'h22, 1'b1);
      in_valid = 1'b1;
      in_data  = 8'hEE;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check($sformatf("stall%0d_valid", k), 32'(out_valid), 32'd1);
         check($sformatf("stall%0d_ready", k), 32'(in_ready),  32'd0);
         check($sformatf("stall%0d_xor", k),   32'(out_xor),   32'h33);
         check($sformatf("stall%0d_count", k), 32'(out_count), 32'd2);
      end
      in_valid = 1'b0;
      check_result("stall", 8'h33, 1'b0, 3'd2, 1'b1);
      handshake("stall");
      send_word(8'h0C, 1'b0);
      send_word(8'h30, 1'b0);
      send_word(8'hC0, 1'b0);
      send_word(8'h03, 1'b0);
      check_result("fresh", 8'hFF, 1'b0, 3'd4, 1'b0);
      handshake("fresh");

      // Mid-frame asynchronous reset discards the partial frame
      send_word(8'h33, 1'b0);
      send_word(8'h44, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst_valid",  32'(out_valid),  32'd0);
      check("midrst_xor",    32'(out_xor),    32'd0);
      check("midrst_count",  32'(out_count),  32'd0);
      check("midrst_short",  32'(out_short),  32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("midrst_ready", 32'(in_ready), 32'd1);
      send_word(8'hA5, 1'b0);
      send_word(8'h00, 1'b0);
      send_word(8'h00, 1'b0);
      check("midrst_no_early_valid", 32'(out_valid), 32'd0);
      send_word(8'h00, 1'b0);
      check_result("midrst", 8'hA5, 1'b0, 3'd4, 1'b0);
      handshake("midrst");

      // Reset while holding a result
      send_word(8'h5A, 1'b1);
      check("holdrst_pre_valid", 32'(out_valid), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("holdrst_valid",  32'(out_valid),  32'd0);
      check("holdrst_xor",    32'(out_xor),    32'd0);
      check("holdrst_parity", 32'(out_parity), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("holdrst_ready", 32'(in_ready), 32'd1);
      send_word(8'h01, 1'b1);
      check_result("holdrst_next", 8'h01, 1'b1, 3'd1, 1'b1);
      handshake("holdrst_next");

`ifdef XOR_FRAME_ACC_OVERLAP_EN
      // Back-to-back frames with out_ready held high
      @(negedge clk);
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         check($sformatf("ovl_ready%0d", i), 32'(in_ready), 32'd1);
         send_word(8'(1 << i), 1'b0);
         if (i == 3) begin
            check("ovl_f1_valid", 32'(out_valid), 32'd1);
            check("ovl_f1_xor",   32'(out_xor),   32'h0F);
         end
      end
      check("ovl_f2_valid", 32'(out_valid), 32'd1);
      check("ovl_f2_xor",   32'(out_xor),   32'hF0);
      check("ovl_f2_count", 32'(out_count), 32'd4);
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check("ovl_drop", 32'(out_valid), 32'd0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/xor_frame_acc.md
# xor_frame_acc

Parametrised streaming XOR accumulator: folds a frame of up to FRAME_LEN WIDTH-bit words into one bitwise-XOR word, a parity bit, a word count and a short-frame flag. It is the multi-cycle successor to the single-gate XOR cell. It sits between a valid/ready word source and a result consumer, and checks link or payload integrity per frame.

## Interface
- WIDTH, 8: data word width in bits (≥1).
- FRAME_LEN, 4: maximum words per frame (≥1).
- CW, $clog2(FRAME_LEN+1): count width, derived; not overridden.
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; asynchronous, active-low.
- in_valid  in  1  input word present.
- in_ready  out  1  block accepts input this cycle.
- in_data  in  WIDTH  input word.
- in_last  in  1  word closes the frame early; sampled only on accept.
- out_valid  out  1  result present.
- out_ready  in  1  consumer takes result.
- out_xor  out  WIDTH  XOR of all words in the frame.
- out_parity  out  1  XOR-reduce of out_xor.
- out_count  out  CW  words in the frame, 1..FRAME_LEN.
- out_short  out  1  1 when the frame closed via in_last with count < FRAME_LEN.

## Operation
- Word accepted when in_valid && in_ready.
- ACCUM state:
  - in_ready=1, out_valid=0.
  - On accept: acc <= acc ^ in_data; cnt <= cnt+1.
  - If cnt+1==FRAME_LEN or in_last: register out_xor=acc^in_data, out_parity=^(acc^in_data), out_count=cnt+1, out_short=in_last && (cnt+1<FRAME_LEN); go HOLD.
- HOLD state:
  - out_valid=1, in_ready=0 (see Configuration).
  - On out_ready: clear acc and cnt to 0; go ACCUM.
- Result outputs stay stable throughout HOLD. Outside HOLD they hold their last values and are don't-care.
- in_last on the FRAME_LEN-th word: frame closes normally, out_short=0.
- FRAME_LEN=1: every accepted word is a complete frame; out_count=1.
- Reset at any time, including mid-frame or in HOLD:
  - State=ACCUM, acc=0, cnt=0, out_valid=0, out_xor=0, out_parity=0, out_count=0, out_short=0.
  - in_ready=1 once rst_n deasserts.
  - The partial frame is discarded and produces no result.
- in_data and in_last are ignored when not accepted.
- No overflow is possible: cnt never exceeds FRAME_LEN-1 in ACCUM.

## Timing
- Latency: out_valid rises on the clock edge that accepts the closing word; visible the next cycle.
- out_valid stays high until the cycle out_ready is sampled high, and drops on that edge.
- Without overlap: one bubble cycle per frame. Minimum frame period is count+1 cycles.
- in_ready is combinational from state only (overlap mode: also from out_ready). No other comb input→output paths.

## Configuration
- XOR_FRAME_ACC_OVERLAP_EN defined:
  - In HOLD, in_ready=out_ready.
  - A word accepted in the same cycle as the result handshake starts the next frame: acc <= in_data, cnt <= 1.
  - If that word also closes the frame (FRAME_LEN=1 or in_last), go straight to a new HOLD with the new result.
  - Back-to-back frames run with zero bubble.
- Not defined: in HOLD, in_ready=0, giving one bubble cycle per frame as described above.

## Test plan
- WIDTH=8, FRAME_LEN=4; words 0x01,0x02,0x04,0x08 with in_last=0 → out_xor=0x0F, out_parity=0, out_count=4, out_short=0, out_valid the cycle after the 4th accept.
- Words 0xFF,0x01 with in_last on the 2nd → out_xor=0xFE, out_parity=1, out_count=2, out_short=1.
- in_last on the 4th word (0x10,0x20,0x40,0x80) → out_xor=0xF0, out_count=4, out_short=0.
- Close a frame, hold out_ready=0 for 5 cycles while in_valid=1 → out_valid and result stable, in_ready=0, no words absorbed; the first word after the handshake starts a fresh frame.
- Accept 0x33,0x44, pulse rst_n low mid-cycle → all outputs 0 immediately; then 0xA5,0x00,0x00,0x00 → out_xor=0xA5, out_parity=0, out_count=4.
- With XOR_FRAME_ACC_OVERLAP_EN and out_ready tied 1, two 4-word frames sent continuously → 8 consecutive accepts with no in_ready gap, two results 4 cycles apart.
